systolic_seq: RTL and testbench

Sequencer for the 4x4 systolic matrix-multiply array. It holds one 4x4 A operand and one 4x4 B operand loaded over a simple write port. On `start` it clears the array accumulators and feeds A rows west and B columns north with the diagonal skew the array needs. It then runs the drain phase, captures the 16 results leaving the SE corner into a local buffer, and streams them out over a valid/ready port. It sits between the host/DMA side and the array, and owns every array control input.

---
 rtl/systolic_seq_if.sv | 34 +++
 rtl/systolic_seq.sv | 173 +++++++++++++++++
 tb/tb_systolic_seq.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_if.sv
// Host-side bus of the systolic sequencer.
//   ld_en/ld_b/ld_addr/ld_data : operand write port (IDLE only)
//   start/busy/done/err        : run control and status
//   res_valid/res_ready        : result handshake
//   res_data/res_idx/res_last  : result payload
// master = host/DMA side, slave = sequencer.
interface systolic_seq_if #(
  parameter int unsigned BW   = 16,
  parameter int unsigned ACCW = 40
);
  logic                   ld_en;
  logic                   ld_b;
  logic [3:0]             ld_addr;
  logic signed [BW-1:0]   ld_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   res_valid;
  logic                   res_ready;
  logic signed [ACCW-1:0] res_data;
  logic [3:0]             res_idx;
  logic                   res_last;

  modport master (
    output ld_en, ld_b, ld_addr, ld_data, start, res_ready,
    input  busy, done, err, res_valid, res_data, res_idx, res_last
  );

  modport slave (
    input  ld_en, ld_b, ld_addr, ld_data, start, res_ready,
    output busy, done, err, res_valid, res_data, res_idx, res_last
  );
endinterface

// File: rtl/systolic_seq.sv
// Sequencer for a 4x4 output-stationary systolic matrix-multiply array.
// Holds the A and B operands, clears the array, feeds A rows west and B columns
// north with diagonal skew, drains the 16 results from the SE corner into a
// local buffer and streams them out over a valid/ready port.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   bus (slave)           : operand load, start/busy/done/err, result stream
//   west_in/west_vld      : A feed, one lane per array row
//   north_in/north_vld    : B feed, one lane per array column
//   acc_clr, out_phase    : array controls
//   se_valid, se_c        : results leaving the SE corner during drain
module systolic_seq #(
  parameter int unsigned BW        = 16,
  parameter int unsigned ACCW      = 40,
  parameter int unsigned FLUSH_CYC = 4,
  parameter int unsigned DRAIN_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_seq_if.slave          bus,
  output logic signed [BW-1:0]   west_in  [4],
  output logic [3:0]             west_vld,
  output logic signed [BW-1:0]   north_in [4],
  output logic [3:0]             north_vld,
  output logic                   acc_clr,
  output logic                   out_phase,
  input  logic                   se_valid,
  input  logic signed [ACCW-1:0] se_c
);

  // Wide enough for the longest phase (drain) and never below 5 bits.
  localparam int unsigned CntW = $clog2(DRAIN_LAT + FLUSH_CYC + 17);

  localparam logic [CntW-1:0] FeedLast  = CntW'(6);
  localparam logic [CntW-1:0] FlushLast = CntW'(FLUSH_CYC - 1);
  localparam logic [CntW-1:0] DrainLat  = CntW'(DRAIN_LAT);
  localparam logic [CntW-1:0] DrainLast = CntW'(DRAIN_LAT + 15);

  typedef enum logic [2:0] {StIdle, StClr, StFeed, StFlush, StDrain, StOut} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   err_q;
  logic                   res_valid_q;
  logic [3:0]             res_idx_q;
  logic                   res_last_q;
  logic signed [ACCW-1:0] res_data_q;

  logic signed [BW-1:0]   a_buf   [16];
  logic signed [BW-1:0]   b_buf   [16];
  logic signed [ACCW-1:0] res_buf [16];

  logic                   capture;
  logic [3:0]             cap_idx;
  logic [1:0]             skew_k;

  assign capture = (state_q == StDrain) && (cnt_q >= DrainLat);
  assign cap_idx = 4'(cnt_q - DrainLat);

  // Control FSM and registered result-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StClr;
            err_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StClr: begin
          state_q <= StFeed;
          cnt_q   <= '0;
        end
        StFeed: begin
          if (cnt_q == FeedLast) begin
            state_q <= StFlush;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFlush: begin
          if (cnt_q == FlushLast) begin
            state_q <= StDrain;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrain: begin
          if (capture && !se_valid) err_q <= 1'b1;
          if (cnt_q == DrainLast) begin
            state_q     <= StOut;
            cnt_q       <= '0;
            res_valid_q <= 1'b1;
            res_idx_q   <= '0;
            res_last_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StOut: begin
          if (bus.res_ready) begin
            if (res_last_q) begin
              state_q     <= StIdle;
              res_valid_q <= 1'b0;
              res_last_q  <= 1'b0;
            end else begin
              res_idx_q  <= res_idx_q + 4'd1;
              res_last_q <= (res_idx_q == 4'd14);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage without reset: operands and results survive a reset.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && bus.ld_en) begin
      if (bus.ld_b) b_buf[bus.ld_addr] <= bus.ld_data;
      else          a_buf[bus.ld_addr] <= bus.ld_data;
    end
    if (capture) res_buf[cap_idx] <= se_c;
    // res_buf[0] is long settled by the last drain cycle.
    if (state_q == StDrain && cnt_q == DrainLast) res_data_q <= res_buf[0];
    if (state_q == StOut && bus.res_ready && !res_last_q) begin
      res_data_q <= res_buf[res_idx_q + 4'd1];
    end
  end

  // Array feed decoded straight from state/cnt: lane i carries element t-i.
  always_comb begin
    west_vld  = '0;
    north_vld = '0;
    skew_k    = '0;
    for (int i = 0; i < 4; i++) begin
      west_in[i]  = '0;
      north_in[i] = '0;
    end
    acc_clr   = (state_q == StClr);
    out_phase = (state_q == StDrain);
    if (state_q == StFeed) begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_q >= CntW'(i) && (cnt_q - CntW'(i)) <= CntW'(3)) begin
          skew_k       = 2'(cnt_q - CntW'(i));
          west_vld[i]  = 1'b1;
          west_in[i]   = a_buf[{2'(i), skew_k}];
          north_vld[i] = 1'b1;
          north_in[i]  = b_buf[{skew_k, 2'(i)}];
        end
      end
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = res_valid_q && bus.res_ready && res_last_q;
  assign bus.err       = err_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_idx   = res_idx_q;
  assign bus.res_last  = res_last_q;

endmodule

// File: tb/tb_systolic_seq.sv
module tb_systolic_seq;
  localparam int unsigned BW        = 16;
  localparam int unsigned ACCW      = 40;
  localparam int unsigned FLUSH_CYC = 4;
  localparam int unsigned DRAIN_LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_seq_if #(.BW(BW), .ACCW(ACCW)) bus ();

  logic signed [BW-1:0]   west_in  [4];
  logic signed [BW-1:0]   north_in [4];
  logic [3:0]             west_vld;
  logic [3:0]             north_vld;
  logic                   acc_clr;
  logic                   out_phase;
  logic                   se_valid;
  logic signed [ACCW-1:0] se_c;

  systolic_seq #(
    .BW(BW), .ACCW(ACCW), .FLUSH_CYC(FLUSH_CYC), .DRAIN_LAT(DRAIN_LAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .west_in(west_in), .west_vld(west_vld),
    .north_in(north_in), .north_vld(north_vld),
    .acc_clr(acc_clr), .out_phase(out_phase),
    .se_valid(se_valid), .se_c(se_c)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Operand mirror and scoreboard
  int ma [16];
  int mb [16];
  logic signed [ACCW-1:0] exp_q [$];
  int  pop_cnt;
  int  start_cyc, first_v_cyc, done_cyc;
  bit  exp_err  = 1'b0;
  bit  tog_mode = 1'b0;
  int  inj_idx  = -1;

  task automatic push_exp();
    for (int i = 0; i < 16; i++) begin
      longint s = 0;
      for (int k = 0; k < 4; k++) s += longint'(ma[(i/4)*4+k]) * longint'(mb[k*4+(i%4)]);
      exp_q.push_back(ACCW'(s));
    end
  endtask

  task automatic wr(input bit is_b, input int idx, input int val, input bit mirror);
    bus.ld_en   = 1'b1;
    bus.ld_b    = is_b;
    bus.ld_addr = 4'(idx);
    bus.ld_data = BW'(val);
    if (mirror) begin
      if (is_b) mb[idx] = val;
      else      ma[idx] = val;
    end
    tick();
    bus.ld_en = 1'b0;
  endtask

  // Leaves the bench in cycle 1 of the run.
  task automatic start_run();
    push_exp();
    pop_cnt     = 0;
    first_v_cyc = -1;
    done_cyc    = -1;
    chk("busy_c0", 64'(bus.busy), 0);
    bus.start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.start = 1'b0;
    chk("busy_c1", 64'(bus.busy), 1);
    chk("acc_clr_c1", 64'(acc_clr), 1);
    chk("err_clr_c1", 64'(bus.err), 0);
  endtask

  task automatic wait_done(input bit want_err);
    int n = 0;
    while (done_cyc < 0 && n < 400) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(done_cyc >= 0), 1);
    chk("busy_after_done", 64'(bus.busy), 0);
    chk("err_after_done", 64'(bus.err), 64'(want_err));
    chk("sb_drained", 64'(exp_q.size()), 0);
  endtask

  // Behavioural output-stationary array driven by the DUT feed.
  logic signed [BW-1:0] pa [4][4];
  logic signed [BW-1:0] pb [4][4];
  bit                   va [4][4];
  bit                   vb [4][4];
  longint               pacc [16];
  int                   dc = 0;

  always @(negedge clk) begin
    if (rst) begin
      dc       = 0;
      se_valid = 1'b0;
      se_c     = '0;
    end else if (acc_clr) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          va[r][c] = 1'b0;
          vb[r][c] = 1'b0;
          pacc[r*4+c] = 0;
        end
      dc = 0;
    end else begin
      for (int r = 3; r >= 0; r--)
        for (int c = 3; c >= 0; c--) begin
          logic signed [BW-1:0] ai, bi;
          bit avi, bvi;
          ai  = (c == 0) ? west_in[r]  : pa[r][c-1];
          avi = (c == 0) ? west_vld[r] : va[r][c-1];
          bi  = (r == 0) ? north_in[c]  : pb[r-1][c];
          bvi = (r == 0) ? north_vld[c] : vb[r-1][c];
          if (avi && bvi) pacc[r*4+c] += longint'(ai) * longint'(bi);
          pa[r][c] = ai;
          va[r][c] = avi;
          pb[r][c] = bi;
          vb[r][c] = bvi;
        end
      if (out_phase) begin
        if (dc >= int'(DRAIN_LAT) && dc < int'(DRAIN_LAT) + 16) begin
          se_c     = ACCW'(pacc[dc-int'(DRAIN_LAT)]);
          se_valid = (dc - int'(DRAIN_LAT)) != inj_idx;
        end else begin
          se_c     = '0;
          se_valid = 1'b0;
        end
        dc++;
      end else begin
        se_valid = 1'b0;
      end
    end
  end

  // Result monitor: scoreboard pop, stall stability, done timing.
  bit                     held_v = 1'b0;
  logic signed [ACCW-1:0] held_d;
  logic [3:0]             held_i;
  logic                   held_l;

  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      bit hs;
      hs = bus.res_valid && bus.res_ready;
      if (bus.res_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (held_v) begin
        chk("stall_valid", 64'(bus.res_valid), 1);
        chk("stall_data", bus.res_data, held_d);
        chk("stall_idx", 64'(bus.res_idx), 64'(held_i));
        chk("stall_last", 64'(bus.res_last), 64'(held_l));
      end
      if (hs) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          logic signed [ACCW-1:0] e;
          e = exp_q.pop_front();
          chk($sformatf("data%0d", pop_cnt), bus.res_data, e);
          chk("idx", 64'(bus.res_idx), 64'(pop_cnt));
          chk("last", 64'(bus.res_last), 64'(pop_cnt == 15));
          chk("done_on_hs", 64'(bus.done), 64'(pop_cnt == 15));
          if (bus.done) begin
            done_cyc = cyc;
            chk("err_at_done", 64'(bus.err), 64'(exp_err));
          end
          pop_cnt++;
        end
      end else begin
        chk("done_idle", 64'(bus.done), 0);
      end
      held_v = bus.res_valid && !bus.res_ready;
      held_d = bus.res_data;
      held_i = bus.res_idx;
      held_l = bus.res_last;
    end
  end

  // res_ready pattern 1,0,0,1,... when toggling, else tied high.
  initial begin
    int pi = 0;
    bus.res_ready = 1'b1;
    forever begin
      tick();
      if (tog_mode) begin
        bus.res_ready = (pi % 4 == 0) || (pi % 4 == 3);
        pi++;
      end else begin
        bus.res_ready = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int wexp [4];
    int nexp [4];
    rst = 1'b1;
    bus.ld_en = 1'b0; bus.ld_b = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.start = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_err", 64'(bus.err), 0);
    chk("rst_res_valid", 64'(bus.res_valid), 0);
    chk("rst_west_vld", 64'(west_vld), 0);
    chk("rst_north_vld", 64'(north_vld), 0);
    rst = 1'b0;
    tick();

    // Run 1: A = identity, B = 4r+c
    for (int i = 0; i < 16; i++) wr(1'b0, i, (i / 4 == i % 4) ? 1 : 0, 1'b1);
    for (int i = 0; i < 16; i++) wr(1'b1, i, i, 1'b1);
    start_run();
    wait_done(1'b0);
    chk("first_valid_cycle", 64'(first_v_cyc - start_cyc), 33);
    chk("done_cycle", 64'(done_cyc - start_cyc), 48);

    // Run 2: feed skew, ignored write in FEED, ignored start in DRAIN, backpressure
    for (int i = 0; i < 16; i++) wr(1'b0, i, 16 * (i / 4) + (i % 4), 1'b1);
    for (int i = 0; i < 16; i++) wr(1'b1, i, 100 + i, 1'b1);
    tog_mode = 1'b1;
    start_run();
    tick();                         // cycle 2, t=0
    tick();                         // t=1
    wr(1'b0, 0, 999, 1'b0);         // ends in t=2
    tick();                         // t=3
    wexp = '{3, 18, 33, 48};
    nexp = '{112, 109, 106, 103};
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("west_in%0d_t3", r), 64'(west_in[r]), 64'(wexp[r]));
      chk($sformatf("north_in%0d_t3", r), 64'(north_in[r]), 64'(nexp[r]));
    end
    chk("west_vld_t3", 64'(west_vld), 64'hf);
    chk("north_vld_t3", 64'(north_vld), 64'hf);
    repeat (3) tick();              // t=6
    chk("west_vld_t6", 64'(west_vld), 64'h8);
    chk("north_vld_t6", 64'(north_vld), 64'h8);
    repeat (12) tick();             // cycle 20, inside DRAIN
    chk("out_phase_drain", 64'(out_phase), 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(1'b0);
    tog_mode = 1'b0;

    // Run 3: reset at FEED t=4, then rerun on retained operands
    start_run();
    repeat (5) tick();              // cycle 6, t=4
    chk("west_vld_t4", 64'(west_vld), 64'he);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("post_rst_busy", 64'(bus.busy), 0);
    chk("post_rst_west_vld", 64'(west_vld), 0);
    chk("post_rst_north_vld", 64'(north_vld), 0);
    chk("post_rst_west_in0", 64'(west_in[0]), 0);
    chk("post_rst_acc_clr", 64'(acc_clr), 0);
    chk("post_rst_out_phase", 64'(out_phase), 0);
    chk("post_rst_res_valid", 64'(bus.res_valid), 0);
    chk("post_rst_done", 64'(bus.done), 0);
    rst = 1'b0;
    tick();
    start_run();
    wait_done(1'b0);

    // Run 4: signed random operands, se_valid dropped at capture 5
    for (int i = 0; i < 16; i++) wr(1'b0, i, int'($urandom_range(0, 65535)) - 32768, 1'b1);
    for (int i = 0; i < 16; i++) wr(1'b1, i, int'($urandom_range(0, 65535)) - 32768, 1'b1);
    inj_idx = 5;
    exp_err = 1'b1;
    start_run();
    wait_done(1'b1);
    inj_idx = -1;
    exp_err = 1'b0;
    start_run();                    // checks err cleared in cycle 1
    wait_done(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
